// File: rtl/async_fifo_prog_if.sv
`timescale 1ns/1ps
// Signal bundle for async_fifo_prog: write side lives in the wclk domain,
// read side in the rclk domain. The FIFO takes the slave view.
interface async_fifo_prog_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  logic                  w_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH:0]   af_thresh;
  logic                  ovf_clr;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;

  logic                  r_en;
  logic [ADDR_WIDTH:0]   ae_thresh;
  logic                  udf_clr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_level;
  logic                  underflow;

  modport master (
    output w_en, wdata, af_thresh, ovf_clr, r_en, ae_thresh, udf_clr,
    input  full, almost_full, wr_level, overflow,
           rdata, rvalid, empty, almost_empty, rd_level, underflow
  );

  modport slave (
    input  w_en, wdata, af_thresh, ovf_clr, r_en, ae_thresh, udf_clr,
    output full, almost_full, wr_level, overflow,
           rdata, rvalid, empty, almost_empty, rd_level, underflow
  );
endinterface

// File: rtl/async_fifo_prog.sv
`timescale 1ns/1ps
// Dual-clock FIFO with gray-pointer synchronizers, programmable almost flags,
// per-domain fill levels, sticky overflow/underflow and optional FWFT read.
module async_fifo_prog #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 9,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 0
) (
  input  logic wclk,
  input  logic wrst_n,
  input  logic rclk,
  input  logic rrst_n,
  async_fifo_prog_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  ptr_t wbin, wgray, wbin_next, wgray_next, rgray_s, wr_level_next;
  ptr_t rgray_sync [SYNC_STAGES];
  logic w_accept;

  assign w_accept      = bus.w_en && !bus.full;
  assign wbin_next     = wbin + ptr_t'(w_accept);
  assign wgray_next    = bin2gray(wbin_next);
  assign rgray_s       = rgray_sync[SYNC_STAGES-1];
  assign wr_level_next = wbin_next - gray2bin(rgray_s);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator runs these blocks.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin            <= '0;
      wgray           <= '0;
      bus.full        <= 1'b0;
      bus.almost_full <= 1'b0;
      bus.wr_level    <= '0;
      bus.overflow    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) rgray_sync[i] <= '0;
    end else begin
      wbin            <= wbin_next;
      wgray           <= wgray_next;
      rgray_sync[0]   <= rgray;
      for (int i = 1; i < SYNC_STAGES; i++) rgray_sync[i] <= rgray_sync[i-1];
      // Full when the write pointer is exactly one lap ahead of the read pointer.
      bus.full        <= (wgray_next == {~rgray_s[PW-1:PW-2], rgray_s[PW-3:0]});
      bus.wr_level    <= wr_level_next;
      bus.almost_full <= (wr_level_next >= bus.af_thresh);
      if (bus.ovf_clr)                bus.overflow <= 1'b0;
      else if (bus.w_en && bus.full)  bus.overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers alone define what is valid,
  // which keeps the array mappable onto RAM.
  always_ff @(posedge wclk) begin
    if (w_accept) mem[wbin[ADDR_WIDTH-1:0]] <= bus.wdata;
  end

  // ---------------- read domain ----------------
  ptr_t rbin, rgray, rbin_next, rgray_next, wgray_s, rd_level_next;
  ptr_t wgray_sync [SYNC_STAGES];
  logic                  r_accept;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  assign r_accept      = bus.r_en && !bus.empty;
  assign rbin_next     = rbin + ptr_t'(r_accept);
  assign rgray_next    = bin2gray(rbin_next);
  assign wgray_s       = wgray_sync[SYNC_STAGES-1];
  assign rd_level_next = gray2bin(wgray_s) - rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin             <= '0;
      rgray            <= '0;
      bus.empty        <= 1'b1;
      bus.almost_empty <= 1'b1;
      bus.rd_level     <= '0;
      bus.underflow    <= 1'b0;
      rdata_q          <= '0;
      rvalid_q         <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) wgray_sync[i] <= '0;
    end else begin
      rbin             <= rbin_next;
      rgray            <= rgray_next;
      wgray_sync[0]    <= wgray;
      for (int i = 1; i < SYNC_STAGES; i++) wgray_sync[i] <= wgray_sync[i-1];
      bus.empty        <= (rgray_next == wgray_s);
      bus.rd_level     <= rd_level_next;
      bus.almost_empty <= (rd_level_next <= bus.ae_thresh);
      rvalid_q         <= r_accept;
      if (r_accept) rdata_q <= mem[rbin[ADDR_WIDTH-1:0]];
      if (bus.udf_clr)                 bus.underflow <= 1'b0;
      else if (bus.r_en && bus.empty)  bus.underflow <= 1'b1;
    end
  end

  // FWFT presents the head word directly; once drained it holds the last popped word.
  if (FWFT != 0) begin : g_fwft
    assign bus.rdata  = bus.empty ? rdata_q : mem[rbin[ADDR_WIDTH-1:0]];
    assign bus.rvalid = !bus.empty;
  end else begin : g_registered
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end
endmodule
